// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: control bit positions and data-bundle
// field layout for the ID/EX, EX/MEM and MEM/WB stage registers.
package pipe_pkg;

    // Stage-register occupancy, encoded as {m_valid, s_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } skid_state_e;

    // ID/EX control bundle
    localparam int IDEX_CTRL_W       = 9;
    localparam int IDEX_REG_DST      = 0;
    localparam int IDEX_ALU_SRC      = 1;
    localparam int IDEX_MEM_TO_REG   = 2;
    localparam int IDEX_REG_WRITE    = 3;
    localparam int IDEX_MEM_READ     = 4;
    localparam int IDEX_MEM_WRITE    = 5;
    localparam int IDEX_BRANCH       = 6;
    localparam int IDEX_ALU_OP_LSB   = 7;
    localparam int IDEX_ALU_OP_W     = 2;

    // EX/MEM control bundle
    localparam int EXMEM_CTRL_W      = 5;
    localparam int EXMEM_REG_WRITE   = 0;
    localparam int EXMEM_MEM_TO_REG  = 1;
    localparam int EXMEM_BRANCH      = 2;
    localparam int EXMEM_MEM_READ    = 3;
    localparam int EXMEM_MEM_WRITE   = 4;

    // MEM/WB control bundle
    localparam int MEMWB_CTRL_W      = 2;
    localparam int MEMWB_REG_WRITE   = 0;
    localparam int MEMWB_MEM_TO_REG  = 1;

    // EX/MEM data bundle layout, LSB first
    localparam int EXMEM_ZERO_LSB          = 0;
    localparam int EXMEM_ZERO_W            = 1;
    localparam int EXMEM_ALU_RESULT_LSB    = 1;
    localparam int EXMEM_ALU_RESULT_W      = 32;
    localparam int EXMEM_READ_DATA2_LSB    = 33;
    localparam int EXMEM_READ_DATA2_W      = 32;
    localparam int EXMEM_WRITE_REG_LSB     = 65;
    localparam int EXMEM_WRITE_REG_W       = 5;
    localparam int EXMEM_BRANCH_TARGET_LSB = 70;
    localparam int EXMEM_BRANCH_TARGET_W   = 32;
    localparam int EXMEM_DATA_W            = 102;

    function automatic logic [EXMEM_CTRL_W-1:0] pack_exmem_ctrl(
        input logic reg_write, input logic mem_to_reg, input logic branch,
        input logic mem_read, input logic mem_write);
        logic [EXMEM_CTRL_W-1:0] c;
        c = '0;
        c[EXMEM_REG_WRITE]  = reg_write;
        c[EXMEM_MEM_TO_REG] = mem_to_reg;
        c[EXMEM_BRANCH]     = branch;
        c[EXMEM_MEM_READ]   = mem_read;
        c[EXMEM_MEM_WRITE]  = mem_write;
        return c;
    endfunction

    function automatic logic [EXMEM_DATA_W-1:0] pack_exmem_data(
        input logic zero, input logic [31:0] alu_result, input logic [31:0] read_data2,
        input logic [4:0] write_reg, input logic [31:0] branch_target);
        logic [EXMEM_DATA_W-1:0] d;
        d = '0;
        d[EXMEM_ZERO_LSB]                                    = zero;
        d[EXMEM_ALU_RESULT_LSB +: EXMEM_ALU_RESULT_W]         = alu_result;
        d[EXMEM_READ_DATA2_LSB +: EXMEM_READ_DATA2_W]         = read_data2;
        d[EXMEM_WRITE_REG_LSB +: EXMEM_WRITE_REG_W]           = write_reg;
        d[EXMEM_BRANCH_TARGET_LSB +: EXMEM_BRANCH_TARGET_W]   = branch_target;
        return d;
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready backpressure and a
// 2-entry skid buffer so in_ready is a pure register output.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = EXMEM_CTRL_W,
    parameter int DATA_W     = EXMEM_DATA_W,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Handshake: a beat moves when valid and ready are both high at a rising
    // edge; valid never depends on ready and in_ready never depends on out_ready.
    logic              m_valid, s_valid, m_valid_n, s_valid_n;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_n, s_ctrl_n;
    logic [DATA_W-1:0] m_data, s_data, m_data_n, s_data_n;
    logic              accept, emit;
    skid_state_e       state;

    assign state     = skid_state_e'({m_valid, s_valid});
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    always_comb begin
        m_valid_n = m_valid;
        s_valid_n = s_valid;
        m_ctrl_n  = m_ctrl;
        s_ctrl_n  = s_ctrl;
        m_data_n  = m_data;
        s_data_n  = s_data;
        if (flush) begin
            // Anything accepted this cycle is dropped; an emitted beat is already gone.
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
            m_ctrl_n  = '0;
            s_ctrl_n  = '0;
            if (CLEAR_DATA) begin
                m_data_n = '0;
                s_data_n = '0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_valid_n = 1'b1;
                        m_ctrl_n  = in_ctrl;
                        m_data_n  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        m_ctrl_n = in_ctrl;
                        m_data_n = in_data;
                    end else if (accept) begin
                        s_valid_n = 1'b1;
                        s_ctrl_n  = in_ctrl;
                        s_data_n  = in_data;
                    end else if (emit) begin
                        m_valid_n = 1'b0;
                    end
                end
                ST_FULL: begin
                    // Skid drains into main before any newer input is taken.
                    if (emit) begin
                        m_ctrl_n  = s_ctrl;
                        m_data_n  = s_data;
                        s_valid_n = 1'b0;
                    end
                end
                default: begin
                    m_valid_n = 1'b0;
                    s_valid_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ctrl  <= '0;
            s_ctrl  <= '0;
            m_data  <= '0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            m_ctrl  <= m_ctrl_n;
            s_ctrl  <= s_ctrl_n;
            m_data  <= m_data_n;
            s_data  <= s_data_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random-handshake bench for pipe_stage_skid; two instances share
// stimulus, one clearing data on flush and one holding it.
module tb_pipe_stage_skid;
    localparam int CW = 5;
    localparam int DW = 102;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          c_in_ready, c_out_valid, h_in_ready, h_out_valid;
    logic [CW-1:0] c_out_ctrl, h_out_ctrl;
    logic [DW-1:0] c_out_data, h_out_data;
    logic [1:0]    c_occ, h_occ;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CW+DW-1:0] exp_q[$];

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) u_dut_clr (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_ctrl(c_out_ctrl),
        .out_data(c_out_data), .occupancy(c_occ)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) u_dut_hold (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_ctrl(h_out_ctrl),
        .out_data(h_out_data), .occupancy(h_occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Compare both instances' handshake outputs against one expected state.
    task automatic check_both(input string tag, input logic ov, input logic [CW-1:0] oc,
                              input logic ir, input logic [1:0] occ);
        check({tag, ".clr.out_valid"}, 128'(c_out_valid), 128'(ov));
        check({tag, ".clr.out_ctrl"},  128'(c_out_ctrl),  128'(oc));
        check({tag, ".clr.in_ready"},  128'(c_in_ready),  128'(ir));
        check({tag, ".clr.occupancy"}, 128'(c_occ),       128'(occ));
        check({tag, ".hold.out_valid"}, 128'(h_out_valid), 128'(ov));
        check({tag, ".hold.occupancy"}, 128'(h_occ),       128'(occ));
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        check_both("reset", 1'b0, 5'b0, 1'b1, 2'd0);
        check("reset.clr.out_data", 128'(c_out_data), 128'h0);
        reset = 1'b0;

        // First beat: 1-cycle latency from empty
        drive(1'b1, 5'b10011, DW'(16'h0ABC), 1'b1);
        tick();
        check_both("first", 1'b1, 5'b10011, 1'b1, 2'd1);
        check("first.out_data", 128'(c_out_data), 128'h0ABC);
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check_both("first_drain", 1'b0, 5'b0, 1'b1, 2'd0);

        // Streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, CW'(i), DW'(i), 1'b1);
            tick();
            check_both($sformatf("stream%0d", i), 1'b1, CW'(i), 1'b1, 2'd1);
            check($sformatf("stream%0d.out_data", i), 128'(c_out_data), 128'(i));
        end
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check_both("stream_drain", 1'b0, 5'b0, 1'b1, 2'd0);

        // Backpressure: A, B, C with out_ready low
        drive(1'b1, 5'h0A, DW'(8'hAA), 1'b0);
        tick();
        check_both("bp_a", 1'b1, 5'h0A, 1'b1, 2'd1);
        drive(1'b1, 5'h0B, DW'(8'hBB), 1'b0);
        tick();
        check_both("bp_b", 1'b1, 5'h0A, 1'b0, 2'd2);
        check("bp_b.out_data", 128'(c_out_data), 128'hAA);
        drive(1'b1, 5'h0C, DW'(8'hCC), 1'b0);
        tick();
        check_both("bp_c_held", 1'b1, 5'h0A, 1'b0, 2'd2);
        check("bp_c_held.out_data", 128'(c_out_data), 128'hAA);
        drive(1'b1, 5'h0C, DW'(8'hCC), 1'b1);
        tick();
        check_both("bp_out_b", 1'b1, 5'h0B, 1'b1, 2'd1);
        check("bp_out_b.out_data", 128'(c_out_data), 128'hBB);
        tick();
        check_both("bp_out_c", 1'b1, 5'h0C, 1'b1, 2'd1);
        check("bp_out_c.out_data", 128'(c_out_data), 128'hCC);
        drive(1'b0, '0, '0, 1'b1);
        tick();
        check_both("bp_drain", 1'b0, 5'b0, 1'b1, 2'd0);

        // Flush in FULL
        drive(1'b1, 5'h1D, DW'(8'hDD), 1'b0);
        tick();
        drive(1'b1, 5'h1E, DW'(8'hEE), 1'b0);
        tick();
        check_both("pre_flush_full", 1'b1, 5'h1D, 1'b0, 2'd2);
        drive(1'b0, '0, '0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_both("flush_full", 1'b0, 5'b0, 1'b1, 2'd0);
        check("flush_full.clr.out_data", 128'(c_out_data), 128'h0);
        check("flush_full.hold.out_data", 128'(h_out_data), 128'hDD);
        check("flush_full.hold.out_ctrl", 128'(h_out_ctrl), 128'h0);

        // Flush with concurrent input: input dropped
        drive(1'b1, 5'h0F, DW'(8'hF0), 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        check_both("flush_in", 1'b0, 5'b0, 1'b1, 2'd0);
        tick();
        check_both("flush_in_after", 1'b0, 5'b0, 1'b1, 2'd0);

        // Reset together with flush from FULL
        drive(1'b1, 5'h11, DW'(8'h11), 1'b0);
        tick();
        drive(1'b1, 5'h12, DW'(8'h22), 1'b0);
        tick();
        check_both("pre_rst_full", 1'b1, 5'h11, 1'b0, 2'd2);
        drive(1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        check_both("rst_flush", 1'b0, 5'b0, 1'b1, 2'd0);
        check("rst_flush.clr.out_data", 128'(c_out_data), 128'h0);
        check("rst_flush.hold.out_data", 128'(h_out_data), 128'h0);

        // Random handshake against a queue model
        begin
            int unsigned seq = 1;
            logic [CW+DW-1:0] head;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                logic v, r, acc, emt;
                v = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 3) != 0);
                drive(v, CW'(seq), DW'({seq, 16'h5A5A}), r);
                check("rnd.in_ready", 128'(c_in_ready), 128'(exp_q.size() < 2));
                check("rnd.occupancy", 128'(c_occ), 128'(exp_q.size()));
                check("rnd.out_valid", 128'(c_out_valid), 128'(exp_q.size() > 0));
                check("rnd.hold.occupancy", 128'(h_occ), 128'(exp_q.size()));
                if (!c_out_valid)
                    check("rnd.idle_ctrl", 128'(c_out_ctrl), 128'h0);
                acc = v && (exp_q.size() < 2);
                emt = r && (exp_q.size() > 0);
                if (emt) begin
                    head = exp_q.pop_front();
                    check("rnd.out_ctrl", 128'(c_out_ctrl), 128'(head[CW+DW-1:DW]));
                    check("rnd.out_data", 128'(c_out_data), 128'(head[DW-1:0]));
                    check("rnd.hold.out_data", 128'(h_out_data), 128'(head[DW-1:0]));
                end
                if (acc) begin
                    exp_q.push_back({CW'(seq), DW'({seq, 16'h5A5A})});
                    seq++;
                end
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
